// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: serializes W-bit valid/ready words MSB-first into a bit-serial
// pattern detector, qualifies its output and counts matches per burst.
//   clk       : clock, all state on posedge
//   rstn      : synchronous active-low reset
//   clr       : zero match_cnt and reset the detector this cycle
//   s_valid   : upstream word valid
//   s_data    : upstream word [W-1:0]
//   s_ready   : word accepted this cycle when s_valid is high
//   det_in    : serial bit to the detector
//   det_rstn  : detector reset (active-low), rstn & ~clr
//   det_out   : detector match output
//   busy      : controller not idle
//   done      : one-cycle pulse, burst complete and match_cnt final
//   match_cnt : qualified matches since last clr/reset [CNT_W-1:0]
// Build option: define MATCH_SAT_EN to make match_cnt saturate instead of wrap.
module seq_det_ctrl #(
  parameter int W       = 8,
  parameter int DET_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             s_valid,
  input  logic [W-1:0]     s_data,
  output logic             s_ready,
  output logic             det_in,
  output logic             det_rstn,
  input  logic             det_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int BW = $clog2(W);
  localparam int DW = DET_LAT > 1 ? $clog2(DET_LAT) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [W-1:0]       sr_q, sr_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [DET_LAT-1:0] pipe_q, pipe_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               shifting, last_bit, hs, hit;

  always_comb begin
    shifting = state_q == SHIFT;
    last_bit = shifting && bit_q == '0;
    s_ready  = rstn && (state_q == IDLE || last_bit);
    hs       = s_valid && s_ready;
    det_in   = rstn && shifting && sr_q[W-1];
    det_rstn = rstn && !clr;
    busy     = state_q != IDLE;
    sr_d     = shifting ? sr_q << 1 : sr_q;
    bit_d    = shifting ? bit_q - BW'(1) : bit_q;
    drain_d  = state_q == DRAIN ? drain_q - DW'(1) : drain_q;
    state_d  = state_q;
    done_d   = 1'b0;
    if (hs) begin
      // a handshake on the last bit reloads in place so the stream stays gapless
      sr_d    = s_data;
      bit_d   = BW'(W - 1);
      state_d = SHIFT;
    end else if (last_bit) begin
      state_d = DRAIN;
      drain_d = DW'(DET_LAT - 1);
    end else if (state_q == DRAIN && drain_q == '0) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    // the qualifier pipe tracks detector latency; a detector reset invalidates it
    pipe_d = clr ? '0 : DET_LAT'({pipe_q, shifting});
    hit    = pipe_q[DET_LAT-1] && det_out;
`ifdef MATCH_SAT_EN
    cnt_d = clr ? '0 : (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
`else
    cnt_d = clr ? '0 : cnt_q + CNT_W'(hit);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      drain_q <= '0;
      pipe_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      drain_q <= drain_d;
      pipe_q  <= pipe_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign match_cnt = cnt_q;
  assign done      = done_q;
endmodule
